// File: rtl/apb_completer_pkg.sv
// Shared types, constants and the access-error decode for the APB register completer.
package apb_completer_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} apb_cmpl_state_e;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_LSB   = 2;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA9B0_0001;

    // Misaligned, below base, past the last word, or a write to the read-only ID word.
    function automatic logic is_err(input logic [31:0] addr, input logic write,
                                    input logic [31:0] base, input int unsigned nregs);
        logic [31:0] word_off;
        word_off = (addr - base) >> ADDR_LSB;
        is_err = (addr[ADDR_LSB-1:0] != '0) || (addr < base) || (word_off >= nregs) ||
                 (write && (word_off == '0));
    endfunction

endpackage

// File: rtl/apb_completer_regs_if.sv
// APB bus bundle between a requester (master) and the register completer (slave).
interface apb_completer_regs_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_completer_regfile.sv
// Byte-strobed word storage; word 0 is a hardwired ID, the rest reset to zero.
module apb_completer_regfile
    import apb_completer_pkg::*;
#(
    parameter int          NUM_REGS = 16,
    parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE,
    localparam int         IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         idx,
    input  logic [31:0]              wdata,
    input  logic [WORD_BYTES-1:0]    strb,
    output logic [31:0]              rd_data,
    output logic [32*NUM_REGS-1:0]   regs_o
);

    logic [31:0] words [NUM_REGS];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
        if (i == 0) begin : g_id
            assign words[i] = ID_VALUE;
        end else begin : g_rw
            logic [31:0] q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (wr_en && (idx == IDX_W'(i))) begin
                    for (int b = 0; b < WORD_BYTES; b++) begin
                        if (strb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            assign words[i] = q;
        end
        assign regs_o[32*i +: 32] = words[i];
    end

    assign rd_data = words[idx];

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer: request capture, wait-state timer and registered response in front of the regfile.
//   state | meaning
//   IDLE  | waiting for SETUP (PSEL & !PENABLE)
//   WAIT  | request captured, counting wait states / honouring stall_i
//   RESP  | PREADY high, completes on PSEL & PENABLE
module apb_completer_regs
    import apb_completer_pkg::*;
#(
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    apb_completer_regs_if.slave    apb,
    input  logic                   stall_i,
    output logic [32*NUM_REGS-1:0] regs_o
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_cmpl_state_e       state;
    logic [3:0]            cnt;
    logic                  cap_write;
    logic                  cap_err;
    logic [IDX_W-1:0]      cap_idx;
    logic [31:0]           cap_wdata;
    logic [WORD_BYTES-1:0] cap_strb;
    logic                  ready_q;
    logic                  slverr_q;
    logic [31:0]           rdata_q;

    logic                  setup;
    logic                  setup_err;
    logic [IDX_W-1:0]      setup_idx;
    logic                  cur_write;
    logic                  cur_err;
    logic [IDX_W-1:0]      rf_idx;
    logic [31:0]           rd_data;
    logic [31:0]           resp_data;
    logic                  complete;
    logic                  wr_en;

    assign setup     = apb.PSEL && !apb.PENABLE;
    assign setup_err = is_err(apb.PADDR, apb.PWRITE, BASE_ADDR, NUM_REGS);
    assign setup_idx = IDX_W'((apb.PADDR - BASE_ADDR) >> ADDR_LSB);

    // In IDLE the response is loaded straight from the live SETUP; afterwards from the capture.
    assign cur_write = (state == IDLE) ? apb.PWRITE : cap_write;
    assign cur_err   = (state == IDLE) ? setup_err  : cap_err;
    assign rf_idx    = (state == IDLE) ? setup_idx  : cap_idx;
    assign resp_data = (!cur_write && !cur_err) ? rd_data : '0;

    assign complete = (state == RESP) && apb.PSEL && apb.PENABLE;
    assign wr_en    = complete && cap_write && !cap_err && !PRESET;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_strb  <= '0;
            ready_q   <= 1'b0;
            slverr_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        cap_write <= apb.PWRITE;
                        cap_err   <= setup_err;
                        cap_idx   <= setup_idx;
                        cap_wdata <= apb.PWDATA;
                        cap_strb  <= apb.PSTRB;
                        if (WAIT_CYCLES == 0 && !stall_i) begin
                            state    <= RESP;
                            ready_q  <= 1'b1;
                            slverr_q <= setup_err;
                            rdata_q  <= resp_data;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    if (!apb.PSEL) begin
                        state <= IDLE;
                    end else begin
                        if (cnt != '0) cnt <= cnt - 4'd1;
                        if (cnt <= 4'd1 && !stall_i) begin
                            state    <= RESP;
                            ready_q  <= 1'b1;
                            slverr_q <= cap_err;
                            rdata_q  <= resp_data;
                        end
                    end
                end
                RESP: begin
                    if (!apb.PSEL || apb.PENABLE) begin
                        state    <= IDLE;
                        ready_q  <= 1'b0;
                        slverr_q <= 1'b0;
                        rdata_q  <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign apb.PREADY  = ready_q;
    assign apb.PSLVERR = slverr_q;
    assign apb.PRDATA  = rdata_q;

    apb_completer_regfile #(
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk     (PCLK),
        .rst     (PRESET),
        .wr_en   (wr_en),
        .idx     (rf_idx),
        .wdata   (cap_wdata),
        .strb    (cap_strb),
        .rd_data (rd_data),
        .regs_o  (regs_o)
    );

endmodule

// File: tb/tb_apb_completer_regs.sv
// Directed bench for the APB register completer: zero-wait and three-wait instances, scoreboarded responses.
module tb_apb_completer_regs;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         sel = 1'b0;
    logic         psel = 1'b0;
    logic         penable = 1'b0;
    logic         pwrite = 1'b0;
    logic [31:0]  paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic [511:0] regs0;
    logic [511:0] regs3;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        which;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    apb_completer_regs_if bus0 ();
    apb_completer_regs_if bus3 ();

    assign bus0.PSEL    = psel && !sel;
    assign bus0.PENABLE = penable;
    assign bus0.PWRITE  = pwrite;
    assign bus0.PADDR   = paddr;
    assign bus0.PWDATA  = pwdata;
    assign bus0.PSTRB   = pstrb;
    assign bus0.PPROT   = 3'b010;
    assign bus3.PSEL    = psel && sel;
    assign bus3.PENABLE = penable;
    assign bus3.PWRITE  = pwrite;
    assign bus3.PADDR   = paddr;
    assign bus3.PWDATA  = pwdata;
    assign bus3.PSTRB   = pstrb;
    assign bus3.PPROT   = 3'b000;

    apb_completer_regs #(.WAIT_CYCLES(0)) u0 (
        .PCLK(clk), .PRESET(rst), .apb(bus0), .stall_i(stall), .regs_o(regs0)
    );
    apb_completer_regs #(.WAIT_CYCLES(3)) u3 (
        .PCLK(clk), .PRESET(rst), .apb(bus3), .stall_i(stall), .regs_o(regs3)
    );

    function automatic logic cur_ready();
        return sel ? bus3.PREADY : bus0.PREADY;
    endfunction

    function automatic logic [31:0] word(input logic which, input int i);
        return which ? regs3[32*i +: 32] : regs0[32*i +: 32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one transfer; the expected response goes to the scoreboard, latency is returned.
    task automatic xfer(input logic which, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input bit b2b, output int lat);
        exp_t e;
        e.which = which; e.rdata = exp_rd; e.err = exp_err;
        exp_q.push_back(e);
        sel = which; psel = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0;
        while (!cur_ready() && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!cur_ready()) begin
            checks++; errors++;
            $display("FAIL timeout addr %h: PREADY never rose", addr);
        end
        @(posedge clk); #1;
        if (!b2b) begin
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    // Scoreboard monitor: every completing ACCESS cycle is matched against the oldest expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic done;
            logic [31:0] rd;
            logic er;
            done = (d == 0) ? (bus0.PSEL && bus0.PENABLE && bus0.PREADY)
                            : (bus3.PSEL && bus3.PENABLE && bus3.PREADY);
            rd   = (d == 0) ? bus0.PRDATA  : bus3.PRDATA;
            er   = (d == 0) ? bus0.PSLVERR : bus3.PSLVERR;
            if (done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp dut%0d: unexpected completion rdata %h err %b", d, rd, er);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.which != d[0] || e.rdata !== rd || e.err !== er) begin
                        errors++;
                        $display("FAIL resp dut%0d: got rdata %h err %b, expected dut%0d rdata %h err %b",
                                 d, rd, er, e.which, e.rdata, e.err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset pready0", {31'd0, bus0.PREADY}, 32'd0);
        check("reset pslverr0", {31'd0, bus0.PSLVERR}, 32'd0);
        check("reset prdata0", bus0.PRDATA, 32'd0);
        check("reset pready3", {31'd0, bus3.PREADY}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("reset u0 word%0d", i), word(1'b0, i), (i == 0) ? ID : 32'd0);
            check($sformatf("reset u3 word%0d", i), word(1'b1, i), (i == 0) ? ID : 32'd0);
        end

        xfer(1'b0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0, lat);
        check("zero-wait write latency", lat, 0);
        check("u0 word1 after write", word(1'b0, 1), 32'hDEADBEEF);
        xfer(1'b0, 1'b0, 32'h04, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b0, lat);
        check("zero-wait read latency", lat, 0);

        xfer(1'b0, 1'b1, 32'h08, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b0, lat);
        xfer(1'b0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b0, lat);
        xfer(1'b0, 1'b0, 32'h08, 32'h0, 4'hF, 32'h11BB33DD, 1'b0, 1'b0, lat);

        xfer(1'b0, 1'b1, 32'h00, 32'h12345678, 4'hF, 32'h0, 1'b1, 1'b0, lat);
        xfer(1'b0, 1'b0, 32'h00, 32'h0, 4'h0, ID, 1'b0, 1'b0, lat);
        xfer(1'b0, 1'b0, 32'h06, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, lat);
        xfer(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, lat);
        xfer(1'b0, 1'b1, 32'h44, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b0, lat);
        xfer(1'b0, 1'b1, 32'h04, 32'h00000000, 4'h0, 32'h0, 1'b0, 1'b0, lat);
        check("u0 word0 still ID", word(1'b0, 0), ID);
        check("u0 word1 after strb0 write", word(1'b0, 1), 32'hDEADBEEF);

        // PENABLE high in IDLE without a SETUP must not start anything.
        sel = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h04;
        repeat (3) begin
            @(posedge clk); #1;
            check("no pready without setup", {31'd0, bus0.PREADY}, 32'd0);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;

        // Three wait states plus stall sampled at the two edges where the count would finish.
        fork
            xfer(1'b1, 1'b1, 32'h04, 32'hCAFE0001, 4'hF, 32'h0, 1'b0, 1'b0, lat);
            begin
                repeat (3) @(posedge clk);
                #1 stall = 1'b1;
                repeat (2) @(posedge clk);
                #1 stall = 1'b0;
            end
        join
        check("wait3 + stall2 latency", lat, 5);
        check("u3 word1 after waited write", word(1'b1, 1), 32'hCAFE0001);
        xfer(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 32'hCAFE0001, 1'b0, 1'b0, lat);
        check("wait3 read latency", lat, 3);

        xfer(1'b0, 1'b1, 32'h08, 32'h5A5A_0F0F, 4'hF, 32'h0, 1'b0, 1'b1, lat);
        xfer(1'b0, 1'b0, 32'h08, 32'h0, 4'h0, 32'h5A5A_0F0F, 1'b0, 1'b0, lat);
        check("back-to-back read latency", lat, 0);

        // PSEL dropped while waiting: transfer abandoned, nothing written.
        sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
        pwdata = 32'h77777777; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("abort no write", word(1'b1, 4), 32'd0);
        xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, lat);

        // Reset pulsed in the middle of a waited write.
        sel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
        pwdata = 32'h55667788; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
        check("reset mid-wait pready", {31'd0, bus3.PREADY}, 32'd0);
        check("reset mid-wait word3", word(1'b1, 3), 32'd0);
        check("reset cleared u3 word1", word(1'b1, 1), 32'd0);
        check("reset cleared u0 word2", word(1'b0, 2), 32'd0);
        repeat (4) @(posedge clk);
        #1 check("no late pready after reset", {31'd0, bus3.PREADY}, 32'd0);
        check("no late write after reset", word(1'b1, 3), 32'd0);
        xfer(1'b1, 1'b1, 32'h0C, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 1'b0, lat);
        check("post-reset write latency", lat, 3);
        xfer(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 1'b0, lat);
        check("post-reset word3", word(1'b1, 3), 32'h0BADF00D);

        repeat (3) @(posedge clk);
        #1 check("scoreboard drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
